// File: rtl/serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_tx_pkg
//
// Shared definitions for the serial word transmitter:
//   - tx_state_e      : FSM state encoding (IDLE / SHIFT / GAP)
//   - WIDTH_MAX       : widest legal word
//   - GAP_MAX         : longest legal inter-word idle gap
//   - params_legal()  : parameter range check, evaluated at elaboration
//   - gap_cnt_width() : width of the gap counter (at least one bit)
// -----------------------------------------------------------------------------
package serial_tx_pkg;

  localparam int WIDTH_MAX = 32;
  localparam int GAP_MAX   = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_e;

  // True when the WIDTH/GAP pair is inside the supported range.
  function automatic bit params_legal(input int width, input int gap);
    return (width >= 2) && (width <= WIDTH_MAX) && (gap >= 0) && (gap <= GAP_MAX);
  endfunction

  // A zero-length gap still needs a one-bit counter so the port widths stay legal.
  function automatic int gap_cnt_width(input int gap);
    return (gap == 0) ? 1 : $clog2(gap + 1);
  endfunction

endpackage : serial_tx_pkg

// File: rtl/piso_shreg.sv
// -----------------------------------------------------------------------------
// piso_shreg
//
// Parallel-in / serial-out shift register. A load captures a full word; each
// shift moves it one position so the next bit reaches the serial tap.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: tap is bit WIDTH-1, shift toward MSB
//              0: tap is bit 0,       shift toward LSB
//
// Ports:
//   clk_i    clock, all updates on posedge
//   rst_i    synchronous, active-high; clears the register
//   load_i   capture data_i (wins over shift_i)
//   shift_i  advance one position
//   data_i   parallel word
//   ser_o    current serial tap (combinational from the register)
// -----------------------------------------------------------------------------
module piso_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ser_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // NOTE: the hold value is assigned first so every path through the block
  // writes shreg_d; without it the tool would infer a latch.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      // Vacated positions fill with zero so an aborted word leaves no residue.
      if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: the data register is reset on purpose: after an aborted word the
  // serial tap must read 0, not stale bits of the old word.
  always_ff @(posedge clk_i) begin
    if (rst_i) shreg_q <= '0;
    else       shreg_q <= shreg_d;
  end

  assign ser_o = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule : piso_shreg

// File: rtl/serial_word_tx.sv
// -----------------------------------------------------------------------------
// serial_word_tx
//
// Valid/ready word stream to single-bit serial stream. One WIDTH-bit word is
// accepted per handshake and sent one bit per clock on ser_d, framed by
// ser_frame, followed by GAP idle cycles and one mandatory IDLE cycle.
//
// Parameters:
//   WIDTH      word width, 2..32
//   GAP        idle cycles after each word's last bit, 0..15
//   MSB_FIRST  1: bit WIDTH-1 first, 0: bit 0 first
//
// Ports:
//   clock0     sole clock, posedge
//   reset      synchronous, active-high
//   in_data    word to send, sampled only on handshake
//   in_valid   in_data valid
//   in_ready   word can be accepted: (state == IDLE) && !reset
//   ser_d      serial data (registered)
//   ser_frame  high exactly while ser_d carries a data bit (registered)
//   busy       high while a word or its gap is on the line (registered)
//
// Timing (handshake sampled at posedge k): bits appear in cycles k+1..k+WIDTH,
// gap cycles follow, and the next handshake edge is k+WIDTH+GAP+1.
// -----------------------------------------------------------------------------
module serial_word_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_d,
  output logic             ser_frame,
  output logic             busy
);

  localparam int BIT_CNT_W = $clog2(WIDTH);
  localparam int GAP_CNT_W = gap_cnt_width(GAP);

  // Counters count down to zero; the load value is the number of remaining
  // cycles after the current one.
  localparam logic [BIT_CNT_W-1:0] BIT_LOAD = BIT_CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

  if (!params_legal(WIDTH, GAP)) begin : g_bad_params
    $error("serial_word_tx: WIDTH must be 2..32 and GAP 0..15");
  end

  tx_state_e            state_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [GAP_CNT_W-1:0] gap_cnt_q;
  logic                 ser_d_q;
  logic                 ser_frame_q;
  logic                 busy_q;

  logic accept;
  logic shift_en;
  logic tap_bit;

  // Ready is masked by reset so a valid held through reset cannot handshake.
  assign in_ready = (state_q == ST_IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign shift_en = (state_q == ST_SHIFT);

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk_i   (clock0),
    .rst_i   (reset),
    .load_i  (accept),
    .shift_i (shift_en),
    .data_i  (in_data),
    .ser_o   (tap_bit)
  );

  // Outputs are registered from the state at the edge: each SHIFT cycle
  // presents the current tap on the line for the following cycle, while the
  // shift register advances in the same edge.
  always_ff @(posedge clock0) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_d_q     <= 1'b0;
      ser_frame_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ser_d_q     <= 1'b0;
      ser_frame_q <= 1'b0;
      busy_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            bit_cnt_q <= BIT_LOAD;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          ser_d_q     <= tap_bit;
          ser_frame_q <= 1'b1;
          busy_q      <= 1'b1;
          if (bit_cnt_q == '0) begin
            if (GAP > 0) begin
              gap_cnt_q <= GAP_LOAD;
              state_q   <= ST_GAP;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - BIT_CNT_W'(1);
          end
        end
        ST_GAP: begin
          busy_q <= 1'b1;
          if (gap_cnt_q == '0) state_q   <= ST_IDLE;
          else                 gap_cnt_q <= gap_cnt_q - GAP_CNT_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ser_d     = ser_d_q;
  assign ser_frame = ser_frame_q;
  assign busy      = busy_q;

endmodule : serial_word_tx

// File: tb/tb_serial_word_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_word_tx
//
// Three transmitters share one clock:
//   dut 0: WIDTH=8 GAP=1 MSB_FIRST=1, observed through a one-flop receiver
//   dut 1: WIDTH=8 GAP=1 MSB_FIRST=0
//   dut 2: WIDTH=8 GAP=0 MSB_FIRST=1
// Stimulus pushes each expected word into a per-dut queue; a monitor rebuilds
// words from the framed serial stream and pops/compares independently.
// Cycle n is the interval after the n-th posedge; inputs change and outputs
// are sampled on the negedge.
// -----------------------------------------------------------------------------
module tb_serial_word_tx;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst [3];
  logic [W-1:0] din [3];
  logic         vld [3];
  logic         rdy [3];
  logic         sd  [3];
  logic         sf  [3];
  logic         bz  [3];

  serial_word_tx #(.WIDTH(W), .GAP(1), .MSB_FIRST(1'b1)) dut_a (
    .clock0(clk), .reset(rst[0]), .in_data(din[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .ser_d(sd[0]), .ser_frame(sf[0]), .busy(bz[0]));

  serial_word_tx #(.WIDTH(W), .GAP(1), .MSB_FIRST(1'b0)) dut_b (
    .clock0(clk), .reset(rst[1]), .in_data(din[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .ser_d(sd[1]), .ser_frame(sf[1]), .busy(bz[1]));

  serial_word_tx #(.WIDTH(W), .GAP(0), .MSB_FIRST(1'b1)) dut_c (
    .clock0(clk), .reset(rst[2]), .in_data(din[2]), .in_valid(vld[2]),
    .in_ready(rdy[2]), .ser_d(sd[2]), .ser_frame(sf[2]), .busy(bz[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One-flop receiver on dut 0, plus registered copies of each reset so the
  // monitor can discard bits still in flight when a reset hit.
  logic rx_d = 1'b0;
  logic rx_f = 1'b0;
  logic rst_q [3];
  always @(posedge clk) begin
    rx_d <= sd[0];
    rx_f <= sf[0];
    for (int i = 0; i < 3; i++) rst_q[i] <= rst[i];
  end

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q [3][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  int           mon_cnt [3];
  logic [W-1:0] mon_acc [3];
  logic         mon_d;
  logic         mon_f;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mon_d = (i == 0) ? rx_d : sd[i];
      mon_f = (i == 0) ? rx_f : sf[i];
      if (rst[i] || rst_q[i]) begin
        mon_cnt[i] = 0;
        mon_acc[i] = '0;
      end else if (mon_f === 1'b1) begin
        if (i == 1) mon_acc[i][mon_cnt[i]]         = mon_d;
        else        mon_acc[i][W - 1 - mon_cnt[i]] = mon_d;
        mon_cnt[i]++;
        if (mon_cnt[i] == W) begin
          mon_cnt[i] = 0;
          if (exp_q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL word_unexpected_dut%0d actual=0x%02h required=none", i, mon_acc[i]);
          end else begin
            check($sformatf("word_dut%0d", i), 32'(mon_acc[i]), 32'(exp_q[i].pop_front()));
          end
        end
      end else if (mon_cnt[i] != 0) begin
        checks++;
        failures++;
        $display("FAIL frame_short_dut%0d actual=%0d_bits required=%0d_bits", i, mon_cnt[i], W);
        mon_cnt[i] = 0;
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  // Waits (bounded) until the dut is ready while valid is high; returns the
  // handshake edge number and leaves time just after that edge.
  task automatic wait_hs(input int id, output int hs);
    hs = -1;
    for (int n = 0; n < 64; n++) begin
      if (rdy[id]) begin
        hs = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (hs < 0) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout_dut%0d actual=no_ready required=ready_within_64", id);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send(input int id, input logic [W-1:0] w, input bit expect_word,
                      input bit hold, output int hs);
    @(negedge clk);
    din[id] = w;
    vld[id] = 1'b1;
    if (expect_word) exp_q[id].push_back(w);
    wait_hs(id, hs);
    if (!hold) begin
      @(negedge clk);
      vld[id] = 1'b0;
    end
  endtask

  initial begin
    int           h;
    int           h0;
    int           h1;
    int           h2;
    int           c;
    logic [W-1:0] wa;
    logic [W-1:0] w;
    logic         e_frame;
    logic         e_d;
    logic         e_busy;
    logic         e_rdy;

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      vld[i] = 1'b0;
      din[i] = '0;
    end
    // Valid held during reset must not produce a handshake.
    vld[0] = 1'b1;
    din[0] = 8'h77;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_outs_dut%0d", i), 32'({rdy[i], bz[i], sf[i], sd[i]}), 32'h0);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    vld[0] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("ready_after_reset_dut%0d", i), 32'(rdy[i]), 32'h1);

    // 0xA5, cycle by cycle relative to handshake edge h:
    // bits in h+1..h+8, gap in h+9, busy h+1..h+9, ready again in h+9
    // (so the next handshake edge is h+10).
    wa = 8'hA5;
    send(0, wa, 1'b1, 1'b1, h);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) vld[0] = 1'b0;
      c       = cyc - h;
      e_frame = (c >= 1) && (c <= 8);
      e_d     = e_frame ? wa[8 - c] : 1'b0;
      e_busy  = (c >= 1) && (c <= 9);
      e_rdy   = (c >= 9);
      check($sformatf("timing_a5_t%0d", c), 32'({rdy[0], bz[0], sf[0], sd[0]}),
            32'({e_rdy, e_busy, e_frame, e_d}));
    end

    // LSB-first words.
    send(1, 8'h01, 1'b1, 1'b0, h);
    send(1, 8'h6B, 1'b1, 1'b0, h);

    // GAP=0, valid held continuously over three words.
    @(negedge clk);
    din[2] = 8'hFF;
    vld[2] = 1'b1;
    exp_q[2].push_back(8'hFF);
    wait_hs(2, h0);
    @(negedge clk);
    din[2] = 8'h00;
    exp_q[2].push_back(8'h00);
    wait_hs(2, h1);
    check("b2b_period_1", 32'(h1 - h0), 32'd9);
    @(negedge clk);
    check("b2b_idle_frame", 32'(sf[2]), 32'h0);
    din[2] = 8'h3C;
    exp_q[2].push_back(8'h3C);
    wait_hs(2, h2);
    check("b2b_period_2", 32'(h2 - h1), 32'd9);
    @(negedge clk);
    vld[2] = 1'b0;

    // Reset during the 4th bit of 0xF0 aborts it; 0x81 follows intact.
    send(0, 8'hF0, 1'b0, 1'b0, h);
    repeat (3) @(negedge clk);
    check("abort_mid_word_frame", 32'(sf[0]), 32'h1);
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort_outs", 32'({rdy[0], bz[0], sf[0], sd[0]}), 32'h0);
    rst[0] = 1'b0;
    #1;
    check("abort_release_ready", 32'(rdy[0]), 32'h1);
    send(0, 8'h81, 1'b1, 1'b0, h);

    // Valid held while busy with in_data changing every cycle.
    @(negedge clk);
    din[0] = 8'h3A;
    vld[0] = 1'b1;
    exp_q[0].push_back(8'h3A);
    wait_hs(0, h);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rdy[0]) break;
      din[0] = 8'(n * 37 + 11);
    end
    vld[0] = 1'b0;
    check("hold_ready_return", 32'(cyc - h), 32'd9);
    repeat (12) @(negedge clk);
    check("hold_no_extra", 32'(exp_q[0].size()), 32'd0);

    // Random words through the receiver flop.
    for (int n = 0; n < 100; n++) begin
      w = 8'($urandom);
      send(0, w, 1'b1, 1'b0, h);
    end

    for (int n = 0; n < 40; n++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("drain_dut%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_word_tx
